lp_decimate_pack: RTL and testbench

LP_DECIMATE_PACK -- requirements
Module: lp_decimate_pack

---
 rtl/lp_decimate_pkg.sv | 13 +
 rtl/lp_decimate_pack_if.sv | 21 ++
 rtl/lp_requant.sv | 46 ++++
 rtl/lp_decimate_pack.sv | 106 ++++++++++
 tb/tb_lp_decimate_pack.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/lp_decimate_pkg.sv
// Shared widths and sample/vector types for the 8-in / 4-kept lowpass decimator.
package lp_decimate_pkg;
  localparam int NSAMP_C    = 8;
  localparam int IN_BITS_C  = 13;
  localparam int OUT_BITS_C = 12;
  localparam int NKEEP_C    = NSAMP_C / 2;

  typedef logic signed [IN_BITS_C-1:0]  in_samp_t;
  typedef logic signed [OUT_BITS_C-1:0] out_samp_t;

  typedef logic [NSAMP_C-1:0][IN_BITS_C-1:0]  in_vec_t;
  typedef logic [NSAMP_C-1:0][OUT_BITS_C-1:0] out_vec_t;
endpackage

// File: rtl/lp_decimate_pack_if.sv
// Sample stream bus of lp_decimate_pack: lowpass beats in, packed decimated frames out.
interface lp_decimate_pack_if
  import lp_decimate_pkg::*;
  ();
  in_vec_t  dat_i;
  logic     dat_valid_i;
  logic     sync_i;
  out_vec_t dat_o;
  logic     dat_valid_o;
  logic     sat_o;

  modport master (
    output dat_i, dat_valid_i, sync_i,
    input  dat_o, dat_valid_o, sat_o
  );

  modport slave (
    input  dat_i, dat_valid_i, sync_i,
    output dat_o, dat_valid_o, sat_o
  );
endinterface

// File: rtl/lp_requant.sv
// One-sample requantizer: halve a signed sample. With LP_DECIMATE_ROUND_EN defined it
// rounds half up and clips to the output range; otherwise it truncates and never clips.
module lp_requant #(
  parameter int IN_BITS  = 13,
  parameter int OUT_BITS = 12
) (
  input  logic signed [IN_BITS-1:0]  x_i,
  output logic signed [OUT_BITS-1:0] y_o,
  output logic                       sat_o
);
`ifdef LP_DECIMATE_ROUND_EN
  localparam logic signed [OUT_BITS-1:0] MAX_C = {1'b0, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [OUT_BITS-1:0] MIN_C = {1'b1, {(OUT_BITS-1){1'b0}}};

  function automatic logic signed [IN_BITS-1:0] round_half_up(input logic signed [IN_BITS-1:0] x);
    logic signed [IN_BITS:0] sum;
    sum = $signed({x[IN_BITS-1], x}) + (IN_BITS+1)'(1);
    return IN_BITS'(sum >>> 1);
  endfunction

  // In range when every bit above the output sign bit matches it.
  function automatic logic in_range(input logic signed [IN_BITS-1:0] v);
    return (&v[IN_BITS-1:OUT_BITS-1]) || !(|v[IN_BITS-1:OUT_BITS-1]);
  endfunction

  function automatic logic signed [OUT_BITS-1:0] saturate(input logic signed [IN_BITS-1:0] v);
    if (in_range(v)) return v[OUT_BITS-1:0];
    return v[IN_BITS-1] ? MIN_C : MAX_C;
  endfunction

  logic signed [IN_BITS-1:0] rnd;

  always_comb begin
    rnd   = round_half_up(x_i);
    y_o   = saturate(rnd);
    sat_o = !in_range(rnd);
  end
`else
  function automatic logic signed [OUT_BITS-1:0] truncate(input logic signed [IN_BITS-1:0] x);
    return OUT_BITS'(x >>> 1);
  endfunction

  assign y_o   = truncate(x_i);
  assign sat_o = 1'b0;
`endif
endmodule

// File: rtl/lp_decimate_pack.sv
// Decimate-by-2 of an 8-sample lowpass beat, requantize to 12 bits and pack two beats
// into one 8-sample output frame. Rounding/saturation selected by LP_DECIMATE_ROUND_EN.
module lp_decimate_pack
  import lp_decimate_pkg::*;
#(
  parameter int NSAMP    = NSAMP_C,
  parameter int IN_BITS  = IN_BITS_C,
  parameter int OUT_BITS = OUT_BITS_C
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  lp_decimate_pack_if.slave  bus
);
  localparam int NKEEP = NSAMP / 2;

  logic [NKEEP-1:0][OUT_BITS-1:0] rq_samp;
  logic [NKEEP-1:0]               rq_sat;
  logic [NKEEP-1:0]               unused_odd;

  for (genvar k = 0; k < NKEEP; k++) begin : g_keep
    lp_requant #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_requant (
      .x_i   (bus.dat_i[2*k]),
      .y_o   (rq_samp[k]),
      .sat_o (rq_sat[k])
    );
    assign unused_odd[k] = ^bus.dat_i[2*k+1];
  end

  // Stage 1: requantized even samples with their qualifiers
  logic [NKEEP-1:0][OUT_BITS-1:0] samp_p1_d, samp_p1_q;
  logic [NKEEP-1:0]               sat_p1_d,  sat_p1_q;
  logic                           vld_p1_d,  vld_p1_q;
  logic                           sync_p1_d, sync_p1_q;

  always_comb begin
    samp_p1_d = rq_samp;
    sat_p1_d  = rq_sat;
    vld_p1_d  = bus.dat_valid_i;
    sync_p1_d = bus.sync_i & bus.dat_valid_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      samp_p1_q <= '0;
      sat_p1_q  <= '0;
      vld_p1_q  <= 1'b0;
      sync_p1_q <= 1'b0;
    end else begin
      samp_p1_q <= samp_p1_d;
      sat_p1_q  <= sat_p1_d;
      vld_p1_q  <= vld_p1_d;
      sync_p1_q <= sync_p1_d;
    end
  end

  // Stage 2: half-frame pairing; sync always restarts a frame, dropping any held half
  logic                           phase_d,    phase_q;
  logic [NKEEP-1:0][OUT_BITS-1:0] hold_d,     hold_q;
  logic                           hold_sat_d, hold_sat_q;
  logic [NSAMP-1:0][OUT_BITS-1:0] dat_p2_d,   dat_p2_q;
  logic                           vld_p2_d,   vld_p2_q;
  logic                           sat_p2_d,   sat_p2_q;

  always_comb begin
    phase_d    = phase_q;
    hold_d     = hold_q;
    hold_sat_d = hold_sat_q;
    dat_p2_d   = dat_p2_q;
    vld_p2_d   = 1'b0;
    sat_p2_d   = 1'b0;
    if (vld_p1_q) begin
      if (!phase_q || sync_p1_q) begin
        hold_d     = samp_p1_q;
        hold_sat_d = |sat_p1_q;
        phase_d    = 1'b1;
      end else begin
        dat_p2_d = {samp_p1_q, hold_q};
        vld_p2_d = 1'b1;
        sat_p2_d = hold_sat_q | (|sat_p1_q);
        phase_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q    <= 1'b0;
      hold_q     <= '0;
      hold_sat_q <= 1'b0;
      dat_p2_q   <= '0;
      vld_p2_q   <= 1'b0;
      sat_p2_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      hold_sat_q <= hold_sat_d;
      dat_p2_q   <= dat_p2_d;
      vld_p2_q   <= vld_p2_d;
      sat_p2_q   <= sat_p2_d;
    end
  end

  assign bus.dat_o       = dat_p2_q;
  assign bus.dat_valid_o = vld_p2_q;
  assign bus.sat_o       = sat_p2_q;
endmodule

// File: tb/tb_lp_decimate_pack.sv
// Directed-vector bench for lp_decimate_pack; expectations follow LP_DECIMATE_ROUND_EN.
module tb_lp_decimate_pack;
  import lp_decimate_pkg::*;

`ifdef LP_DECIMATE_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  lp_decimate_pack_if bus ();

  lp_decimate_pack #(.NSAMP(8), .IN_BITS(13), .OUT_BITS(12)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    in_vec_t  h1;
    in_vec_t  h2;
    out_vec_t exp_t;
    out_vec_t exp_r;
    logic     sat_r;
  } vec_t;

  vec_t tbl [6];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input in_vec_t d, input logic v, input logic s);
    bus.dat_i       = d;
    bus.dat_valid_i = v;
    bus.sync_i      = s;
  endtask

  function automatic in_vec_t one_in(input int idx, input int val);
    in_vec_t v;
    v      = '0;
    v[idx] = 13'(val);
    return v;
  endfunction

  function automatic out_vec_t two_out(input int i0, input int v0, input int i1, input int v1);
    out_vec_t v;
    v     = '0;
    v[i0] = 12'(v0);
    v[i1] = 12'(v1);
    return v;
  endfunction

  initial begin
    out_vec_t exp_o;
    logic     exp_s;
    int       frames;

    for (int i = 0; i < 6; i++) tbl[i] = '0;
    // impulse at even index 2 -> output index 1
    tbl[0].h1[2] = 13'sd1000;
    tbl[0].exp_t[1] = 12'sd500;  tbl[0].exp_r[1] = 12'sd500;
    // odd samples dropped, first and second half
    tbl[1].h1[3] = 13'sd1000;
    tbl[2].h2[3] = 13'sd1000;    tbl[2].h2[7] = -13'sd1000;
    // full-scale extremes
    tbl[3].h1[0] = 13'sd4095;    tbl[3].h1[2] = 13'h1000;
    tbl[3].exp_t[0] = 12'sd2047; tbl[3].exp_t[1] = 12'h800;
    tbl[3].exp_r[0] = 12'sd2047; tbl[3].exp_r[1] = 12'h800;
    tbl[3].sat_r = 1'b1;
    // -3: truncation floors to -2, rounding gives -1
    tbl[4].h1[0] = -13'sd3;      tbl[4].h2[6] = -13'sd3;
    tbl[4].exp_t[0] = -12'sd2;   tbl[4].exp_t[7] = -12'sd2;
    tbl[4].exp_r[0] = -12'sd1;   tbl[4].exp_r[7] = -12'sd1;
    // mixed values with junk on odd lanes
    tbl[5].h1[0] = 13'sd100;  tbl[5].h1[2] = -13'sd200; tbl[5].h1[4] = 13'sd7;  tbl[5].h1[6] = -13'sd1;
    tbl[5].h2[0] = 13'sd2;    tbl[5].h2[2] = 13'sd3;    tbl[5].h2[4] = -13'sd5; tbl[5].h2[6] = 13'sd4094;
    tbl[5].h1[1] = 13'sd1234; tbl[5].h1[5] = -13'sd777; tbl[5].h2[3] = 13'sd4095; tbl[5].h2[7] = 13'h1000;
    tbl[5].exp_t[0] = 12'sd50;  tbl[5].exp_t[1] = -12'sd100; tbl[5].exp_t[2] = 12'sd3;  tbl[5].exp_t[3] = -12'sd1;
    tbl[5].exp_t[4] = 12'sd1;   tbl[5].exp_t[5] = 12'sd1;    tbl[5].exp_t[6] = -12'sd3; tbl[5].exp_t[7] = 12'sd2047;
    tbl[5].exp_r[0] = 12'sd50;  tbl[5].exp_r[1] = -12'sd100; tbl[5].exp_r[2] = 12'sd4;  tbl[5].exp_r[3] = 12'sd0;
    tbl[5].exp_r[4] = 12'sd1;   tbl[5].exp_r[5] = 12'sd2;    tbl[5].exp_r[6] = -12'sd2; tbl[5].exp_r[7] = 12'sd2047;

    // Reset held with valid traffic on the input
    drive(one_in(0, 500), 1'b1, 1'b1);
    step(); step(); step();
    chk("reset_dat",   bus.dat_o, '0);
    chk("reset_valid", bus.dat_valid_o, 0);
    chk("reset_sat",   bus.sat_o, 0);
    drive('0, 1'b0, 1'b0);
    rst_ni = 1'b1;

    // Single frames from the table
    for (int i = 0; i < 6; i++) begin
      exp_o = ROUND ? tbl[i].exp_r : tbl[i].exp_t;
      exp_s = ROUND ? tbl[i].sat_r : 1'b0;
      step(); drive(tbl[i].h1, 1'b1, 1'b1);
      step(); drive(tbl[i].h2, 1'b1, 1'b0);
      step(); drive('0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_valid_early", i), bus.dat_valid_o, 0);
      step();
      chk($sformatf("vec%0d_valid", i), bus.dat_valid_o, 1);
      chk($sformatf("vec%0d_dat", i), bus.dat_o, exp_o);
      chk($sformatf("vec%0d_sat", i), bus.sat_o, exp_s);
      step();
      chk($sformatf("vec%0d_valid_off", i), bus.dat_valid_o, 0);
      chk($sformatf("vec%0d_sat_off", i), bus.sat_o, 0);
      chk($sformatf("vec%0d_dat_hold", i), bus.dat_o, exp_o);
    end

    // Continuous ramp: 8 back-to-back beats -> 4 frames on alternate cycles
    frames = 0;
    for (int c = 0; c < 12; c++) begin
      int o;
      in_vec_t beat;
      step();
      beat = '0;
      for (int k = 0; k < 8; k++) beat[k] = 13'(16 * c + 2 * k);
      if (c < 8) drive(beat, 1'b1, c == 0);
      else       drive('0, 1'b0, 1'b0);
      o = c - 2;
      chk($sformatf("ramp_valid_c%0d", c), bus.dat_valid_o, (o >= 1 && o <= 7 && (o % 2) == 1));
      if (bus.dat_valid_o === 1'b1 && o >= 1) begin
        int f;
        f = (o - 1) / 2;
        for (int j = 0; j < 8; j++) begin
          int b;
          b = (j < 4) ? 2 * f : 2 * f + 1;
          exp_o[j] = 12'((16 * b + 4 * (j % 4)) >>> 1);
        end
        chk($sformatf("ramp_dat_f%0d", f), bus.dat_o, exp_o);
        frames++;
      end
    end
    total++;
    if (frames != 4) begin
      bad++;
      $display("FAIL ramp_frames: got %0d expected 4", frames);
    end

    // Mid-frame asynchronous reset discards the held half
    step(); drive(one_in(0, 200), 1'b1, 1'b1);
    step(); drive('0, 1'b0, 1'b0);
    step();
    #3 rst_ni = 1'b0;
    #1;
    chk("async_rst_dat",   bus.dat_o, '0);
    chk("async_rst_valid", bus.dat_valid_o, 0);
    chk("async_rst_sat",   bus.sat_o, 0);
    step(); step();
    rst_ni = 1'b1;
    step(); drive(one_in(0, 600), 1'b1, 1'b0);
    step(); drive(one_in(0, 800), 1'b1, 1'b0);
    step(); drive('0, 1'b0, 1'b0);
    chk("post_rst_no_early_frame", bus.dat_valid_o, 0);
    step();
    chk("post_rst_valid", bus.dat_valid_o, 1);
    chk("post_rst_dat",   bus.dat_o, two_out(0, 300, 4, 400));

    // Resync after a gap, unqualified sync ignored, gap between halves tolerated
    step(); drive(one_in(0, 10), 1'b1, 1'b1);
    for (int g = 0; g < 5; g++) begin
      step(); drive(one_in(0, 999), 1'b0, 1'b1);
      chk($sformatf("gap1_valid_%0d", g), bus.dat_valid_o, 0);
    end
    step(); drive(one_in(0, 20), 1'b1, 1'b1);
    for (int g = 0; g < 3; g++) begin
      step(); drive(one_in(2, 999), 1'b0, 1'b0);
      chk($sformatf("gap2_valid_%0d", g), bus.dat_valid_o, 0);
    end
    step(); drive(one_in(0, 30), 1'b1, 1'b0);
    step(); drive('0, 1'b0, 1'b0);
    chk("resync_valid_early", bus.dat_valid_o, 0);
    step();
    chk("resync_valid", bus.dat_valid_o, 1);
    chk("resync_dat",   bus.dat_o, two_out(0, 10, 4, 15));
    step();
    chk("resync_valid_off", bus.dat_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
